// File: rtl/wb_regfile.sv
// wb_regfile: writeback mux, 32x32 register file (x0 hardwired to 0) and committed-write counter.
// Optional macro WB_REGFILE_BYPASS_EN makes reads of the register being written return WBdata_o in the same cycle.
module wb_regfile #(
  parameter int COUNT_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        mem_i,
  input  logic [31:0]        ALUResult_i,
  input  logic [31:0]        RDaddr_i,
  input  logic               RegWrite_i,
  input  logic               MemtoReg_i,
  input  logic [4:0]         RS1addr_i,
  input  logic [4:0]         RS2addr_i,
  output logic [31:0]        RS1data_o,
  output logic [31:0]        RS2data_o,
  output logic [31:0]        WBdata_o,
  output logic [COUNT_W-1:0] wb_count_o
);
  logic [31:0]        r_regs [32];
  logic [COUNT_W-1:0] r_count;
  logic [4:0]         w_wa;
  logic               w_we;
  logic               w_byp1;
  logic               w_byp2;
  logic               w_unused;
  assign w_unused   = ^RDaddr_i[31:5];
  assign w_wa       = RDaddr_i[4:0];
  assign w_we       = RegWrite_i && (w_wa != 5'd0);
  assign WBdata_o   = MemtoReg_i ? mem_i : ALUResult_i;
  assign wb_count_o = r_count;
`ifdef WB_REGFILE_BYPASS_EN
  // Write-through is masked during reset so reads stay 0 while rst_i is low.
  assign w_byp1 = rst_i && w_we && (RS1addr_i == w_wa);
  assign w_byp2 = rst_i && w_we && (RS2addr_i == w_wa);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif
  assign RS1data_o = w_byp1 ? WBdata_o : (RS1addr_i == 5'd0) ? 32'd0 : r_regs[RS1addr_i];
  assign RS2data_o = w_byp2 ? WBdata_o : (RS2addr_i == 5'd0) ? 32'd0 : r_regs[RS2addr_i];
  // Commit a writeback to a nonzero register and count it; asynchronous clear on reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < 32; k++) r_regs[k] <= 32'd0;
      r_count <= '0;
    end else if (w_we) begin
      r_regs[w_wa] <= WBdata_o;
      r_count      <= r_count + 1'b1;
    end
  end
endmodule
